// File: rtl/axi4dma_ctrl_pkg.sv
// Register map, status bit layout and small helpers shared by the DMA control/status register file.
// Pure declarations; no logic or state.
package axi4dma_ctrl_pkg;

    localparam logic [10:0] ADDR_VERSION = 11'h000;
    localparam logic [10:0] ADDR_START   = 11'h004;
    localparam logic [10:0] ADDR_BUSY    = 11'h008;
    localparam logic [10:0] ADDR_PENDING = 11'h00C;
    localparam logic [10:0] ADDR_ABORT   = 11'h010;
    localparam logic [10:0] ADDR_CH_BASE = 11'h040;

    localparam int ST_DONE    = 0;
    localparam int ST_WRERR   = 1;
    localparam int ST_RDERR   = 2;
    localparam int ST_BADDESC = 3;
    localparam int ST_W       = 4;
    localparam int ST_BD_LSB  = 16;
    localparam int BD_W       = 5;

    typedef struct packed {
        logic              vld;
        logic [ST_W-1:0]   typ;
        logic [BD_W-1:0]   bd;
    } evt_t;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    function automatic logic [31:0] status_word(input logic [ST_W-1:0] st, input logic [BD_W-1:0] bd);
        logic [31:0] w;
        w = '0;
        w[ST_W-1:0] = st;
        w[ST_BD_LSB +: BD_W] = bd;
        return w;
    endfunction

endpackage

// File: rtl/axi4dma_int_channel.sv
// One interrupt channel: sticky W1C status, first-event BD, mask and level interrupt.
// Status/mask update on the strobe edge, interrupt one cycle later; no backpressure.
module axi4dma_int_channel
    import axi4dma_ctrl_pkg::*;
(
    input  logic              core_clk,
    input  logic              arst_n,
    input  evt_t              evt,
    input  logic [ST_W-1:0]   w1c_dat,
    input  logic              mask_vld,
    input  logic [ST_W-1:0]   mask_dat,
    output logic [ST_W-1:0]   status,
    output logic [BD_W-1:0]   bd,
    output logic [ST_W-1:0]   mask,
    output logic              irq
);

    logic [ST_W-1:0] status_nxt;

    // Event bits are OR'd after the clear so a coincident event wins over W1C.
    always_comb begin
        status_nxt = (status & ~w1c_dat) | (evt.vld ? evt.typ : '0);
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            status <= '0;
            bd     <= '0;
            mask   <= '0;
            irq    <= 1'b0;
        end else begin
            status <= status_nxt;
            if (status == '0 && status_nxt != '0) begin
                bd <= evt.bd;
            end else if (status_nxt == '0) begin
                bd <= '0;
            end
            if (mask_vld) begin
                mask <= mask_dat;
            end
            irq <= |(status & mask);
        end
    end

endmodule

// File: rtl/axi4dma_ctrl_status_regs.sv
// DMA control/status register file: start queuing, abort pulses, per-channel interrupts, registered reads.
// Write ack and read data one cycle after the strobe; start/abort pulses one cycle after decision; no backpressure.
module axi4dma_ctrl_status_regs
    import axi4dma_ctrl_pkg::*;
#(
    parameter int          NUM_INT_BDS = 4,
    parameter int          NUM_INT     = 1,
    parameter logic [7:0]  MAJOR_VER   = 8'd2,
    parameter logic [7:0]  MINOR_VER   = 8'd0,
    parameter logic [7:0]  SUB_VER     = 8'd0
)(
    input  logic                    CLOCK,
    input  logic                    RESETN,
    input  logic                    ctrlWrEn,
    input  logic                    ctrlRdEn,
    input  logic [10:0]             ctrlAddr,
    input  logic [31:0]             ctrlWrData,
    input  logic [3:0]              ctrlWrStrb,
    output logic                    ctrlWrAck,
    output logic [31:0]             ctrlRdData,
    output logic                    ctrlRdValid,
    input  logic [NUM_INT_BDS-1:0]  bdBusy,
    output logic [NUM_INT_BDS-1:0]  startBD,
    output logic [NUM_INT_BDS-1:0]  abortBD,
    input  logic                    evtValid,
    input  logic [1:0]              evtChan,
    input  logic [3:0]              evtType,
    input  logic [4:0]              evtBD,
    output logic [NUM_INT-1:0]      INTERRUPT
);

    logic [10:0]              word_addr;
    logic [31:0]              wr_bits;
    logic                     wr_start;
    logic                     wr_abort;
    logic                     ch_hit;
    logic [1:0]               ch_sel;
    logic                     ch_is_mask;
    logic [NUM_INT_BDS-1:0]   pending;
    logic [NUM_INT_BDS-1:0]   start_req;
    logic [NUM_INT_BDS-1:0]   abort_req;
    logic [NUM_INT_BDS-1:0]   req_any;
    logic [NUM_INT_BDS-1:0]   start_nxt;
    logic [NUM_INT_BDS-1:0]   pending_nxt;
    logic [31:0]              busy32;
    logic [31:0]              pend32;
    logic [31:0]              rd_mux;
    logic                     unused_ok;

    logic [NUM_INT-1:0][ST_W-1:0] ch_status;
    logic [NUM_INT-1:0][BD_W-1:0] ch_bd;
    logic [NUM_INT-1:0][ST_W-1:0] ch_mask;

    assign word_addr  = {ctrlAddr[10:2], 2'b00};
    assign wr_bits    = ctrlWrData & strb_to_mask(ctrlWrStrb);
    assign wr_start   = ctrlWrEn && (word_addr == ADDR_START);
    assign wr_abort   = ctrlWrEn && (word_addr == ADDR_ABORT);
    assign ch_hit     = (word_addr[10:5] == ADDR_CH_BASE[10:5]);
    assign ch_sel     = word_addr[4:3];
    assign ch_is_mask = word_addr[2];
    assign unused_ok  = ^{ctrlAddr[1:0], wr_bits};

    assign start_req  = wr_start ? wr_bits[NUM_INT_BDS-1:0] : '0;
    assign abort_req  = wr_abort ? wr_bits[NUM_INT_BDS-1:0] : '0;

    // A request (new or queued) fires once the BD is idle; abort kills both the pulse and the queue.
    assign req_any     = pending | start_req;
    assign start_nxt   = req_any & ~bdBusy & ~abort_req;
    assign pending_nxt = req_any &  bdBusy & ~abort_req;

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            pending     <= '0;
            startBD     <= '0;
            abortBD     <= '0;
            ctrlWrAck   <= 1'b0;
            ctrlRdValid <= 1'b0;
            ctrlRdData  <= '0;
        end else begin
            pending     <= pending_nxt;
            startBD     <= start_nxt;
            abortBD     <= abort_req;
            ctrlWrAck   <= ctrlWrEn;
            ctrlRdValid <= ctrlRdEn;
            if (ctrlRdEn) begin
                ctrlRdData <= rd_mux;
            end
        end
    end

    for (genvar g = 0; g < NUM_INT; g++) begin : g_ch
        evt_t            ch_evt;
        logic [ST_W-1:0] ch_w1c;
        logic            ch_mask_vld;

        assign ch_evt.vld  = evtValid && (evtChan == 2'(g));
        assign ch_evt.typ  = evtType;
        assign ch_evt.bd   = evtBD;
        assign ch_w1c      = (ctrlWrEn && ch_hit && ch_sel == 2'(g) && !ch_is_mask) ? wr_bits[ST_W-1:0] : '0;
        assign ch_mask_vld = ctrlWrEn && ch_hit && ch_sel == 2'(g) && ch_is_mask && ctrlWrStrb[0];

        axi4dma_int_channel u_ch (
            .core_clk (CLOCK),
            .arst_n   (RESETN),
            .evt      (ch_evt),
            .w1c_dat  (ch_w1c),
            .mask_vld (ch_mask_vld),
            .mask_dat (ctrlWrData[ST_W-1:0]),
            .status   (ch_status[g]),
            .bd       (ch_bd[g]),
            .mask     (ch_mask[g]),
            .irq      (INTERRUPT[g])
        );
    end

    always_comb begin
        busy32 = '0;
        pend32 = '0;
        busy32[NUM_INT_BDS-1:0] = bdBusy;
        pend32[NUM_INT_BDS-1:0] = pending;
    end

    // Read mux sees pre-write state, so a same-cycle read returns the old value.
    always_comb begin
        rd_mux = '0;
        case (word_addr)
            ADDR_VERSION: rd_mux = {8'h00, MAJOR_VER, MINOR_VER, SUB_VER};
            ADDR_BUSY:    rd_mux = busy32;
            ADDR_PENDING: rd_mux = pend32;
            default: begin
                if (ch_hit) begin
                    for (int i = 0; i < NUM_INT; i++) begin
                        if (ch_sel == 2'(i)) begin
                            rd_mux = ch_is_mask ? {28'h0, ch_mask[i]} : status_word(ch_status[i], ch_bd[i]);
                        end
                    end
                end
            end
        endcase
    end

endmodule
